mips_register_file: RTL

- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALUSrc 2-to-1 mux: read_data2 drives that mux's i0 input, and read_data1 drives ALU operand A.
- Sits directly downstream of the RegDst mux (write_reg) and the MemtoReg mux (write_data).
- Two asynchronous read ports and one synchronous write port; $zero is hardwired; an optional write-to-read bypass is provided.

---
 rtl/mips_register_file_if.sv | 25 ++
 rtl/mips_register_file.sv | 38 +++
 2 files changed

// File: rtl/mips_register_file_if.sv
// rtl/mips_register_file_if.sv - register file access bus with write, two read and debug peek ports
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_addr,
    input  read_data1, read_data2, dbg_data
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_addr,
    output read_data1, read_data2, dbg_data
  );
endinterface

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32-entry MIPS register file, 2 async reads, 1 sync write, hardwired $zero
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  mips_register_file_if.slave rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;
  logic                  byp1;
  logic                  byp2;

  // Address 0 is excluded here so $zero is never stored and the bypass never fires for it.
  assign wr_en = rf.reg_write && !reset_i && (rf.write_reg != '0);
  assign byp1  = BYPASS && wr_en && (rf.write_reg == rf.read_reg1);
  assign byp2  = BYPASS && wr_en && (rf.write_reg == rf.read_reg2);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rf.write_reg] <= rf.write_data;
    end
  end

  assign rf.read_data1 = (reset_i || rf.read_reg1 == '0) ? '0 :
                         byp1 ? rf.write_data : regs_q[rf.read_reg1];
  assign rf.read_data2 = (reset_i || rf.read_reg2 == '0) ? '0 :
                         byp2 ? rf.write_data : regs_q[rf.read_reg2];
  assign rf.dbg_data   = (reset_i || rf.dbg_addr == '0) ? '0 : regs_q[rf.dbg_addr];
endmodule
